// File: rtl/dccm_arb.sv
// dccm_arb: arbitrates the single DCCM port between the LSU and the DMA slave.
// The LSU has priority, and a starvation counter bounds how long the DMA can wait.
// Read data returns one cycle after the grant.
// Build option DCCM_ARB_RMW_EN:
//   - When defined, partial-byte DMA writes run a locked read-merge-write sequence.
//   - When undefined, a partial-byte DMA write is refused with dma_done + dma_err.
module dccm_arb #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    output logic                lsu_gnt,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [ADDR_W-1:0]   dma_addr,
    input  logic [DATA_W-1:0]   dma_wdata,
    input  logic [DATA_W/8-1:0] dma_be,
    output logic                dma_gnt,
    output logic                dma_rvalid,
    output logic [DATA_W-1:0]   dma_rdata,
    output logic                dma_done,
    output logic                dma_err,
    output logic                dccm_rden,
    output logic                dccm_wren,
    output logic [ADDR_W-1:0]   dccm_rd_addr,
    output logic [ADDR_W-1:0]   dccm_wr_addr,
    output logic [DATA_W-1:0]   dccm_wr_data,
    input  logic [DATA_W-1:0]   dccm_rd_data
);

    localparam int         BE_W       = DATA_W / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic              idle;
    logic              be_full;
    logic              be_part;
    logic              rmw_start;
    logic              rmw_wr;
    logic [ADDR_W-1:0] rmw_wr_addr;
    logic [DATA_W-1:0] rmw_wr_data;

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       rd_pend_q, rd_pend_d;
    logic       owner_q, owner_d;        // 1 = DMA owns the outstanding read
    logic       dma_done_q, dma_done_d;
    logic       dma_err_q, dma_err_d;

    assign be_full = &dma_be;
    assign be_part = !be_full && (|dma_be);

`ifdef DCCM_ARB_RMW_EN
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RMW_MERGE = 2'd1,
        RMW_WR    = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] rmw_addr_q;
    logic [DATA_W-1:0] rmw_wdata_q;
    logic [BE_W-1:0]   rmw_be_q;
    logic [DATA_W-1:0] wbuf_q;
    logic [DATA_W-1:0] merge_data;

    assign idle        = (state_q == IDLE);
    assign rmw_wr      = (state_q == RMW_WR);
    assign rmw_start   = dma_gnt && dma_we && be_part;
    assign rmw_wr_addr = rmw_addr_q;
    assign rmw_wr_data = wbuf_q;

    // Byte-wise merge: enabled bytes come from the DMA, others from memory.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge
        assign merge_data[gi*8 +: 8] = rmw_be_q[gi] ? rmw_wdata_q[gi*8 +: 8]
                                                    : dccm_rd_data[gi*8 +: 8];
    end

    // RMW sequencer: latch the partial write, merge with read data, write back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rmw_addr_q  <= '0;
            rmw_wdata_q <= '0;
            rmw_be_q    <= '0;
            wbuf_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rmw_start) begin
                        rmw_addr_q  <= dma_addr;
                        rmw_wdata_q <= dma_wdata;
                        rmw_be_q    <= dma_be;
                        state_q     <= RMW_MERGE;
                    end
                end
                RMW_MERGE: begin
                    wbuf_q  <= merge_data;
                    state_q <= RMW_WR;
                end
                RMW_WR:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    assign idle        = 1'b1;
    assign rmw_wr      = 1'b0;
    assign rmw_start   = 1'b0;
    assign rmw_wr_addr = '0;
    assign rmw_wr_data = '0;
`endif

    // DMA wins when the LSU is silent or the DMA has waited STARVE_MAX cycles.
    assign dma_gnt = idle && dma_req && (!lsu_req || (starve_cnt_q == STARVE_LIM));
    assign lsu_gnt = idle && lsu_req && !dma_gnt;

    // Memory strobes follow the grant combinationally; RMW write-back overrides.
    always_comb begin
        dccm_rden    = (lsu_gnt && !lsu_we) || (dma_gnt && !dma_we) || rmw_start;
        dccm_rd_addr = dma_gnt ? dma_addr : lsu_addr;
        dccm_wren    = (lsu_gnt && lsu_we) || (dma_gnt && dma_we && be_full) || rmw_wr;
        dccm_wr_addr = rmw_wr ? rmw_wr_addr : (dma_gnt ? dma_addr : lsu_addr);
        dccm_wr_data = rmw_wr ? rmw_wr_data : (dma_gnt ? dma_wdata : lsu_wdata);
    end

    // Next-state for return flags, completion pulses and the starvation counter.
    always_comb begin
        rd_pend_d = (lsu_gnt && !lsu_we) || (dma_gnt && !dma_we);
        owner_d   = dma_gnt;
`ifdef DCCM_ARB_RMW_EN
        dma_done_d = (dma_gnt && dma_we && !be_part) || rmw_wr;
        dma_err_d  = 1'b0;
`else
        dma_done_d = dma_gnt && dma_we;
        dma_err_d  = dma_gnt && dma_we && be_part;
`endif
        starve_cnt_d = starve_cnt_q;
        if (idle) begin
            if (dma_gnt || !dma_req) begin
                starve_cnt_d = 4'd0;
            end else if (lsu_gnt && (starve_cnt_q < STARVE_LIM)) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    // Registered single-cycle pulses and arbitration state.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
            rd_pend_q    <= 1'b0;
            owner_q      <= 1'b0;
            dma_done_q   <= 1'b0;
            dma_err_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= rd_pend_d;
            owner_q      <= owner_d;
            dma_done_q   <= dma_done_d;
            dma_err_q    <= dma_err_d;
        end
    end

    assign lsu_rvalid = rd_pend_q && !owner_q;
    assign dma_rvalid = rd_pend_q && owner_q;
    assign lsu_rdata  = lsu_rvalid ? dccm_rd_data : '0;
    assign dma_rdata  = dma_rvalid ? dccm_rd_data : '0;
    assign dma_done   = dma_done_q;
    assign dma_err    = dma_err_q;

endmodule

// File: tb/tb_dccm_arb.sv
// Scoreboard bench for dccm_arb.
// Stimulus pushes timestamped expectations into per-channel queues.
// A negedge monitor pops each queue when the matching DUT output fires,
// and flags missing or unexpected events.
// Expectations follow the build selected by DCCM_ARB_RMW_EN.
module tb_dccm_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req, lsu_we;
    logic [15:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_gnt, lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        dma_req, dma_we;
    logic [15:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_be;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        dma_done, dma_err;
    logic        dccm_rden, dccm_wren;
    logic [15:0] dccm_rd_addr, dccm_wr_addr;
    logic [31:0] dccm_wr_data;
    logic [31:0] dccm_rd_data = 32'h0;

    dccm_arb #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_be(dma_be), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .dma_done(dma_done), .dma_err(dma_err),
        .dccm_rden(dccm_rden), .dccm_wren(dccm_wren),
        .dccm_rd_addr(dccm_rd_addr), .dccm_wr_addr(dccm_wr_addr),
        .dccm_wr_data(dccm_wr_data), .dccm_rd_data(dccm_rd_data)
    );

    always #5 clk = ~clk;

    // Simple one-cycle-latency memory behind the arbiter.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (dccm_wren) mem[dccm_wr_addr[7:0]] <= dccm_wr_data;
        if (dccm_rden) dccm_rd_data <= mem[dccm_rd_addr[7:0]];
    end

    // Channels: 0 rden addr, 1 wren {addr,data}, 2 lsu read, 3 dma read,
    // 4 dma_done (value = dma_err), 5 dma_err without dma_done.
    typedef struct {
        int          cyc;
        logic [63:0] val;
    } exp_t;

    exp_t        exp_q [6][$];
    int          rd_idx [6];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        gnt_chk = 1'b0;
    logic [1:0]  exp_gnt = 2'b00;
    logic        idle_chk = 1'b0;
    logic        fin = 1'b0;
    logic        mon_fire [6];
    logic [63:0] mon_act [6];
    exp_t        mon_e;

    function automatic string ch_name(input int ch);
        case (ch)
            0:       return "dccm_rden";
            1:       return "dccm_wren";
            2:       return "lsu_read";
            3:       return "dma_read";
            4:       return "dma_done";
            default: return "dma_err_alone";
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        mon_fire[0] = dccm_rden;             mon_act[0] = 64'(dccm_rd_addr);
        mon_fire[1] = dccm_wren;             mon_act[1] = {16'h0, dccm_wr_addr, dccm_wr_data};
        mon_fire[2] = lsu_rvalid;            mon_act[2] = 64'(lsu_rdata);
        mon_fire[3] = dma_rvalid;            mon_act[3] = 64'(dma_rdata);
        mon_fire[4] = dma_done;              mon_act[4] = 64'(dma_err);
        mon_fire[5] = dma_err && !dma_done;  mon_act[5] = 64'(dma_err);
        if (gnt_chk) chk("grant", 64'({lsu_gnt, dma_gnt}), 64'(exp_gnt));
        if (idle_chk)
            chk("reset_outputs", 64'({lsu_gnt, dma_gnt, lsu_rvalid, dma_rvalid,
                                      dma_done, dma_err, dccm_rden, dccm_wren}), 64'd0);
        for (int ch = 0; ch < 6; ch++) begin
            if (mon_fire[ch]) begin
                if (rd_idx[ch] < exp_q[ch].size()) begin
                    mon_e = exp_q[ch][rd_idx[ch]];
                    rd_idx[ch]++;
                    $display("[TB] cycle %0d %s value 0x%0h", cyc, ch_name(ch), mon_act[ch]);
                    chk({ch_name(ch), "_value"}, mon_act[ch], mon_e.val);
                    chk({ch_name(ch), "_cycle"}, 64'(cyc), 64'(mon_e.cyc));
                end else begin
                    chk({ch_name(ch), "_unexpected"}, 64'(mon_fire[ch]), 64'd0);
                end
            end else if (rd_idx[ch] < exp_q[ch].size() && exp_q[ch][rd_idx[ch]].cyc <= cyc) begin
                rd_idx[ch]++;
                chk({ch_name(ch), "_missing"}, 64'(mon_fire[ch]), 64'd1);
            end
        end
        if (fin) begin
            for (int ch = 0; ch < 6; ch++)
                chk({ch_name(ch), "_drained"}, 64'(rd_idx[ch]), 64'(exp_q[ch].size()));
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end else if (cyc > 2000) begin
            chk("timeout", 64'(fin), 64'd1);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    task automatic drive(input logic lr, input logic lw, input logic [15:0] la, input logic [31:0] lwd,
                         input logic dr, input logic dw, input logic [15:0] da, input logic [31:0] dwd,
                         input logic [3:0] dbe, input logic [1:0] eg);
        lsu_req = lr; lsu_we = lw; lsu_addr = la; lsu_wdata = lwd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dwd; dma_be = dbe;
        gnt_chk  = 1'b1;
        exp_gnt  = eg;
        idle_chk = 1'b0;
    endtask

    // lat = cycles after the current one at which the event must appear.
    task automatic expect_ev(input int ch, input int lat, input logic [63:0] v);
        exp_t e;
        e.cyc = cyc + 1 + lat;
        e.val = v;
        exp_q[ch].push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        drive(0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0, 4'h0, 2'b00);
        step();
    endtask

    // Both requesters read continuously: LSU x4 then DMA, repeating.
    task automatic starve_run(input int n, input logic [31:0] d20);
        for (int k = 0; k < n; k++) begin
            if (k % 5 == 4) begin
                drive(1, 0, 16'h10, 32'h0, 1, 0, 16'h20, 32'h0, 4'h0, 2'b01);
                expect_ev(0, 0, 64'h20);
                expect_ev(3, 1, 64'(d20));
            end else begin
                drive(1, 0, 16'h10, 32'h0, 1, 0, 16'h20, 32'h0, 4'h0, 2'b10);
                expect_ev(0, 0, 64'h10);
                expect_ev(2, 1, 64'hDEADBEEF);
            end
            step();
        end
    endtask

    logic [31:0] m20;

    initial begin
        rst = 1'b1;
        lsu_req = 0; lsu_we = 0; lsu_addr = 0; lsu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_be = 0;
        step();
        step();
        rst = 1'b0;
        drive(0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0, 4'h0, 2'b00);
        idle_chk = 1'b1;
        step();

        // LSU full-word writes preload the memory.
        drive(1, 1, 16'h10, 32'hDEADBEEF, 0, 0, 16'h0, 32'h0, 4'h0, 2'b10);
        expect_ev(1, 0, {16'h0, 16'h0010, 32'hDEADBEEF});
        step();
        drive(1, 1, 16'h20, 32'h11223344, 0, 0, 16'h0, 32'h0, 4'h0, 2'b10);
        expect_ev(1, 0, {16'h0, 16'h0020, 32'h11223344});
        step();

        // LSU read, then DMA read whose grant coincides with the LSU rvalid.
        drive(1, 0, 16'h10, 32'h0, 0, 0, 16'h0, 32'h0, 4'h0, 2'b10);
        expect_ev(0, 0, 64'h10);
        expect_ev(2, 1, 64'hDEADBEEF);
        step();
        drive(0, 0, 16'h0, 32'h0, 1, 0, 16'h20, 32'h0, 4'h0, 2'b01);
        expect_ev(0, 0, 64'h20);
        expect_ev(3, 1, 64'h11223344);
        step();

        // DMA full-word write, then read it back.
        drive(0, 0, 16'h0, 32'h0, 1, 1, 16'h30, 32'hCAFEF00D, 4'hF, 2'b01);
        expect_ev(1, 0, {16'h0, 16'h0030, 32'hCAFEF00D});
        expect_ev(4, 1, 64'd0);
        step();
        drive(0, 0, 16'h0, 32'h0, 1, 0, 16'h30, 32'h0, 4'h0, 2'b01);
        expect_ev(0, 0, 64'h30);
        expect_ev(3, 1, 64'hCAFEF00D);
        step();

        // DMA write with zero byte enables: granted, no strobes, clean done.
        drive(0, 0, 16'h0, 32'h0, 1, 1, 16'h10, 32'h0, 4'h0, 2'b01);
        expect_ev(4, 1, 64'd0);
        step();
        idle_cyc();

        // Starvation bound with both requesters held.
        starve_run(12, 32'h11223344);
        idle_cyc();

        // Partial DMA write to 0x20 with be=0101.
`ifdef DCCM_ARB_RMW_EN
        drive(0, 0, 16'h0, 32'h0, 1, 1, 16'h20, 32'hAABBCCDD, 4'b0101, 2'b01);
        expect_ev(0, 0, 64'h20);
        expect_ev(1, 2, {16'h0, 16'h0020, 32'h11BB33DD});
        expect_ev(4, 3, 64'd0);
        step();
        drive(1, 0, 16'h10, 32'h0, 0, 0, 16'h0, 32'h0, 4'h0, 2'b00);
        step();
        drive(1, 0, 16'h10, 32'h0, 0, 0, 16'h0, 32'h0, 4'h0, 2'b00);
        step();
        m20 = 32'h11BB33DD;
`else
        drive(0, 0, 16'h0, 32'h0, 1, 1, 16'h20, 32'hAABBCCDD, 4'b0101, 2'b01);
        expect_ev(4, 1, 64'd1);
        step();
        m20 = 32'h11223344;
`endif
        drive(1, 0, 16'h10, 32'h0, 0, 0, 16'h0, 32'h0, 4'h0, 2'b10);
        expect_ev(0, 0, 64'h10);
        expect_ev(2, 1, 64'hDEADBEEF);
        step();
        drive(1, 0, 16'h20, 32'h0, 0, 0, 16'h0, 32'h0, 4'h0, 2'b10);
        expect_ev(0, 0, 64'h20);
        expect_ev(2, 1, 64'(m20));
        step();
        idle_cyc();

        // Reset asserted in the cycle after a partial-write grant.
        drive(0, 0, 16'h0, 32'h0, 1, 1, 16'h20, 32'h00000000, 4'b0011, 2'b01);
`ifdef DCCM_ARB_RMW_EN
        expect_ev(0, 0, 64'h20);
`else
        expect_ev(4, 1, 64'd1);
`endif
        step();
        drive(0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0, 4'h0, 2'b00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0, 4'h0, 2'b00);
        idle_chk = 1'b1;
        step();

        // Starvation counter restarts from zero after reset.
        starve_run(5, m20);
        drive(1, 0, 16'h20, 32'h0, 0, 0, 16'h0, 32'h0, 4'h0, 2'b10);
        expect_ev(0, 0, 64'h20);
        expect_ev(2, 1, 64'(m20));
        step();

        idle_cyc();
        idle_cyc();
        idle_cyc();
        fin = 1'b1;
    end

endmodule

// File: doc/dccm_arb.md
# dccm_arb

Arbiter and sequencer for the DCCM port pair between the LSU and the DMA slave.
- Grants one memory operation per cycle, with LSU priority and a starvation bound for DMA.
- Returns read data with fixed latency.
- Converts DMA partial-word writes into a locked read-merge-write sequence.
- Sits between the LSU/DMA front-ends and the DCCM wrapper's `dccm_wren`/`dccm_rden` port group.

## Interface
Parameters:
- ADDR_W, 16, DCCM address width (matches `RV_DCCM_BITS`)
- DATA_W, 32, data word width; byte enables are DATA_W/8 bits
- STARVE_MAX, 4, LSU-won cycles with DMA pending before DMA is forced (1..15)

Ports (clock is `clk`; reset is `rst`, synchronous and active-high):
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- lsu_req / lsu_we  in  1 / 1  LSU request, write flag
- lsu_addr / lsu_wdata  in  ADDR_W / DATA_W  LSU address, write data (full word)
- lsu_gnt  out  1  combinational grant, same cycle as request
- lsu_rvalid / lsu_rdata  out  1 / DATA_W  read return
- dma_req / dma_we  in  1 / 1  DMA request, write flag
- dma_addr / dma_wdata / dma_be  in  ADDR_W / DATA_W / DATA_W/8  DMA address, data, byte enables
- dma_gnt  out  1  combinational grant
- dma_rvalid / dma_rdata  out  1 / DATA_W  read return
- dma_done / dma_err  out  1 / 1  write completion pulse; error pulse
- dccm_rden / dccm_wren  out  1 / 1  memory strobes
- dccm_rd_addr / dccm_wr_addr  out  ADDR_W  memory addresses
- dccm_wr_data  out  DATA_W  memory write data
- dccm_rd_data  in  DATA_W  memory read data, valid the cycle after `dccm_rden`

## Operation
States: IDLE, RMW_MERGE, RMW_WR.

**IDLE**
- At most one grant per cycle.
- Winner is DMA when `dma_req && (!lsu_req || starve_cnt==STARVE_MAX)`; otherwise LSU wins if `lsu_req`.
- Requesters hold `req` and operands stable until `gnt`.
- `starve_cnt` (4-bit, saturating at STARVE_MAX):
  - increments when `dma_req && lsu_gnt`
  - clears on `dma_gnt` or `!dma_req`

**Granted read**
- Drives `dccm_rden` and `dccm_rd_addr` in the grant cycle.
- Next cycle: the owner's `rvalid`=1 and `rdata`=`dccm_rd_data`.
- A 1-bit owner register records LSU or DMA.

**Granted LSU write, or DMA write with `dma_be` all ones**
- Drives `dccm_wren`, `dccm_wr_addr` and `dccm_wr_data` in the grant cycle.
- A DMA write pulses `dma_done` the next cycle.

**DMA write with `dma_be`==0**
- Granted.
- No memory access.
- `dma_done` next cycle.

**DMA partial write (`dma_be` not all ones and not zero)**
- Handling depends on Configuration.
- RMW sequence:
  - Grant cycle: drive `dccm_rden` at `dma_addr`; latch addr, wdata, be; go to RMW_MERGE.
  - RMW_MERGE: `wbuf` = per byte, `be[i]` ? `wdata` byte : `dccm_rd_data` byte; go to RMW_WR.
  - RMW_WR: `dccm_wren`=1 with the latched address and `wbuf`; go to IDLE; `dma_done` pulses the next cycle.
- During RMW_MERGE and RMW_WR, `lsu_gnt` and `dma_gnt` are 0. `starve_cnt` does not change.

**Reset**
- All outputs, state, `starve_cnt`, the owner register and return pipeline flags go to 0/IDLE.
- Reset during RMW abandons the sequence: no `dccm_wren`, no `dma_done`.

## Timing
- Grant: 0-cycle combinational from `req`.
- Read data: grant cycle + 1.
- Full write: memory write in the grant cycle; `dma_done` at grant + 1.
- RMW write: `dccm_wren` at grant + 2; `dma_done` at grant + 3.
- Next grant is possible at the RMW_WR cycle + 1.
- Memory strobes are combinational from the grant/FSM.
- `rvalid`, `rdata` select, `dma_done` and `dma_err` are registered single-cycle pulses.
- Back-to-back grants every cycle in IDLE.
- `rvalid` of operation N coincides with the grant of operation N+1.

## Configuration
Macro `DCCM_ARB_RMW_EN`:
- **Defined:** partial DMA writes execute the RMW sequence above.
- **Undefined:** the RMW states and merge buffer are compiled out; a partial DMA write is granted, performs no memory access, and pulses `dma_done`=1 and `dma_err`=1 at grant + 1.
- Full-word and zero-byte-enable behaviour is identical in both builds.

## Test plan
- **LSU read:** mem[0x10]=0xDEADBEEF; `lsu_req` read 0x10 → `lsu_gnt` same cycle, `dccm_rden`=1 addr 0x10, `lsu_rvalid`=1 with `lsu_rdata`=0xDEADBEEF one cycle later.
- **Starvation bound:** `lsu_req` and `dma_req` held continuously, STARVE_MAX=4 → LSU granted 4 cycles, DMA granted on the 5th, LSU resumes the 6th; pattern repeats.
- **RMW merge:** mem[0x20]=0x11223344; DMA write 0xAABBCCDD with be=4'b0101 (RMW_EN) → `dccm_wren` at grant + 2 with data 0x11BB33DD, `dma_done` at grant + 3, `lsu_gnt`=0 during both locked cycles despite `lsu_req`=1.
- **No-RMW build:** same stimulus with `DCCM_ARB_RMW_EN` undefined → no `dccm_wren`, `dma_err`=1 and `dma_done`=1 at grant + 1, mem[0x20] unchanged.
- **Reset mid-RMW:** assert `rst` in the RMW_MERGE cycle → next cycle state IDLE, no `dccm_wren`, no `dma_done`, mem unchanged, `starve_cnt`=0.
- **Zero byte enables:** DMA write be=0 → granted, no strobes, `dma_done` at grant + 1, `dma_err`=0.
